// File: rtl/bsg_mcl_rcv_drain_arbiter.sv
// Round-robin drain scheduler: captures whole packets from parallel receive FIFOs and
// serializes them LSB word first onto one host read channel. Optional: BSG_MCL_DRAIN_PKT_COUNT_EN.
module bsg_mcl_rcv_drain_arbiter #(
    parameter int num_slots_p  = 4,
    parameter int fifo_width_p = 128,
    parameter int word_width_p = 32,
    localparam int els_lp        = fifo_width_p / word_width_p,
    localparam int slot_width_lp = (num_slots_p > 1) ? $clog2(num_slots_p) : 1,
    localparam int beat_width_lp = (els_lp > 1) ? $clog2(els_lp) : 1
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_slots_p-1:0]              v_i,
    input  logic [num_slots_p*fifo_width_p-1:0] data_i,
    output logic [num_slots_p-1:0]              yumi_o,
    output logic                                v_o,
    output logic [word_width_p-1:0]             data_o,
    output logic [slot_width_lp-1:0]            slot_o,
    output logic                                last_o,
    input  logic                                yumi_i,
    output logic                                busy_o,
    output logic [31:0]                         pkt_count_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                    state_r;
    logic [slot_width_lp-1:0]  rr_ptr_r;
    logic [slot_width_lp-1:0]  slot_r;
    logic [beat_width_lp-1:0]  beat_r;
    logic [fifo_width_p-1:0]   pkt_r;

    logic [slot_width_lp-1:0]  grant;
    logic [slot_width_lp-1:0]  rr_next;
    logic [31:0]               scan_idx;
    logic                      found;
    logic                      any_v;
    logic                      last_beat;
    logic                      pkt_done;
    logic                      capture_en;
    logic [fifo_width_p-1:0]   grant_data;

    assign any_v = |v_i;

    // Scan slots starting at rr_ptr and wrapping; the first valid slot wins.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int unsigned i = 0; i < num_slots_p; i++) begin
            scan_idx = 32'(rr_ptr_r) + i;
            if (scan_idx >= 32'(num_slots_p)) begin
                scan_idx = scan_idx - 32'(num_slots_p);
            end
            if (!found && v_i[slot_width_lp'(scan_idx)]) begin
                found = 1'b1;
                grant = slot_width_lp'(scan_idx);
            end
        end
    end

    assign rr_next = (grant == slot_width_lp'(num_slots_p - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < num_slots_p; i++) begin
            if (grant == slot_width_lp'(i)) begin
                grant_data = data_i[i*fifo_width_p +: fifo_width_p];
            end
        end
    end

    assign last_beat = (state_r == SEND) && (beat_r == beat_width_lp'(els_lp - 1));
    assign pkt_done  = last_beat && yumi_i;

    // Gated by reset so a dequeue can never be issued while the block is held in reset.
    assign capture_en = reset_n_i && any_v && ((state_r == IDLE) || pkt_done);

    always_comb begin
        yumi_o = '0;
        if (capture_en) begin
            yumi_o[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            slot_r   <= '0;
            beat_r   <= '0;
            pkt_r    <= '0;
        end else if (capture_en) begin
            state_r  <= SEND;
            pkt_r    <= grant_data;
            slot_r   <= grant;
            beat_r   <= '0;
            rr_ptr_r <= rr_next;
        end else if ((state_r == SEND) && yumi_i) begin
            if (last_beat) begin
                state_r <= IDLE;
            end else begin
                beat_r <= beat_r + 1'b1;
            end
        end
    end

    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < els_lp; i++) begin
            if (beat_r == beat_width_lp'(i)) begin
                data_o = pkt_r[i*word_width_p +: word_width_p];
            end
        end
    end

    assign v_o    = (state_r == SEND);
    assign busy_o = (state_r == SEND);
    assign last_o = last_beat;
    assign slot_o = slot_r;

`ifdef BSG_MCL_DRAIN_PKT_COUNT_EN
    logic [31:0] pkt_count_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pkt_count_r <= '0;
        end else if (pkt_done) begin
            pkt_count_r <= pkt_count_r + 32'd1;
        end
    end

    assign pkt_count_o = pkt_count_r;
`else
    assign pkt_count_o = '0;
`endif

    host_yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
    );

endmodule

// File: tb/tb_bsg_mcl_rcv_drain_arbiter.sv
// Scoreboard bench for bsg_mcl_rcv_drain_arbiter: directed packets push expected beats,
// a negedge monitor pops and compares every consumed beat.
module tb_bsg_mcl_rcv_drain_arbiter;

    localparam int NS = 4;
    localparam int FW = 128;
    localparam int WW = 32;

`ifdef BSG_MCL_DRAIN_PKT_COUNT_EN
    localparam logic [31:0] EXP_CNT3 = 32'd3;
`else
    localparam logic [31:0] EXP_CNT3 = 32'd0;
`endif

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
        logic        l;
    } beat_t;

    logic              clk;
    logic              reset_n;
    logic [NS-1:0]     v_i;
    logic [NS*FW-1:0]  data_i;
    logic [NS-1:0]     yumi_o;
    logic              v_o;
    logic [WW-1:0]     data_o;
    logic [1:0]        slot_o;
    logic              last_o;
    logic              yumi_i;
    logic              busy_o;
    logic [31:0]       pkt_count_o;
    logic              host_rdy;

    int    checks = 0;
    int    errors = 0;
    beat_t sb[$];

    bsg_mcl_rcv_drain_arbiter #(
        .num_slots_p (NS),
        .fifo_width_p(FW),
        .word_width_p(WW)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .v_i        (v_i),
        .data_i     (data_i),
        .yumi_o     (yumi_o),
        .v_o        (v_o),
        .data_o     (data_o),
        .slot_o     (slot_o),
        .last_o     (last_o),
        .yumi_i     (yumi_i),
        .busy_o     (busy_o),
        .pkt_count_o(pkt_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host only consumes a presented beat, so yumi_i never arrives without v_o.
    assign yumi_i = host_rdy & v_o;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_pkt(input int s);
        logic [127:0] p;
        p = '0;
        for (int k = 0; k < 4; k++) begin
            if (s == 2) p[k*32 +: 32] = 32'h1111_1111 * 32'(k + 1);
            else        p[k*32 +: 32] = 32'hA000_0000 + 32'(s) * 32'h100 + 32'(k);
        end
        return p;
    endfunction

    task automatic push_pkt(input int s);
        logic [127:0] p;
        beat_t        b;
        p = mk_pkt(s);
        for (int k = 0; k < 4; k++) begin
            b.d = p[k*32 +: 32];
            b.s = 2'(s);
            b.l = (k == 3);
            sb.push_back(b);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_left"}, 128'(sb.size()), 128'd0);
        @(negedge clk);
        chk({name, "_idle_v_o"}, 128'(v_o), 128'd0);
    endtask

    // Monitor: every consumed beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && yumi_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat act data=%0h slot=%0d exp none", data_o, slot_o);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat_data", 128'(data_o), 128'(e.d));
                chk("beat_slot", 128'(slot_o), 128'(e.s));
                chk("beat_last", 128'(last_o), 128'(e.l));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_y;
        reset_n  = 1'b0;
        host_rdy = 1'b0;
        v_i      = '1;
        for (int s = 0; s < NS; s++) data_i[s*FW +: FW] = mk_pkt(s);

        // Reset state, with all slots valid to show no dequeue during reset.
        repeat (2) @(negedge clk);
        chk("rst_v_o", 128'(v_o), 128'd0);
        chk("rst_yumi_o", 128'(yumi_o), 128'd0);
        chk("rst_busy_o", 128'(busy_o), 128'd0);
        chk("rst_last_o", 128'(last_o), 128'd0);
        chk("rst_slot_o", 128'(slot_o), 128'd0);
        chk("rst_pkt_count", 128'(pkt_count_o), 128'd0);
        @(posedge clk); #1;
        v_i     = '0;
        reset_n = 1'b1;
        @(posedge clk);

        // All slots valid: grants 0,1,2,3,0 with back-to-back beats.
        @(posedge clk); #1;
        v_i = 4'b1111;
        host_rdy = 1'b1;
        push_pkt(0); push_pkt(1); push_pkt(2); push_pkt(3); push_pkt(0);
        @(negedge clk);
        chk("rr_grant0", 128'(yumi_o), 128'b0001);
        chk("rr_busy_idle", 128'(busy_o), 128'd0);
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            chk("rr_no_bubble", 128'(v_o), 128'd1);
            if (n % 4 == 0) begin
                exp_y = 4'b0001 << ((n / 4) % 4);
                chk("rr_grant", 128'(yumi_o), 128'(exp_y));
            end
        end
        @(posedge clk); #1;
        v_i = '0;
        wait_drain("rr");

        // Slot 2 alone: dequeue then beats on the following cycles.
        @(posedge clk); #1;
        v_i = 4'b0100;
        push_pkt(2);
        @(negedge clk);
        chk("s2_yumi_o", 128'(yumi_o), 128'b0100);
        @(posedge clk); #1;
        v_i = '0;
        @(negedge clk);
        chk("s2_latency_v_o", 128'(v_o), 128'd1);
        chk("s2_busy_o", 128'(busy_o), 128'd1);
        wait_drain("s2");

        // Host stall at beat 1 for five cycles.
        @(posedge clk); #1;
        v_i = 4'b0100;
        push_pkt(2);
        @(posedge clk); #1;
        v_i = '0;
        @(posedge clk); #1;
        host_rdy = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("stall_data_o", 128'(data_o), 128'h2222_2222);
            chk("stall_v_o", 128'(v_o), 128'd1);
            chk("stall_last_o", 128'(last_o), 128'd0);
        end
        @(posedge clk); #1;
        host_rdy = 1'b1;
        wait_drain("stall");

        // Async reset mid-cycle while holding a slot-3 packet at beat 2.
        @(posedge clk); #1;
        v_i = 4'b1000;
        push_pkt(3);
        @(posedge clk); #1;
        v_i = '0;
        @(posedge clk);
        @(posedge clk); #1;
        host_rdy = 1'b0;
        chk("pre_rst_data_o", 128'(data_o), 128'hA000_0302);
        #2;
        sb.delete();
        v_i     = 4'b1010;
        reset_n = 1'b0;
        #1;
        chk("async_v_o", 128'(v_o), 128'd0);
        chk("async_busy_o", 128'(busy_o), 128'd0);
        chk("async_last_o", 128'(last_o), 128'd0);
        chk("async_yumi_o", 128'(yumi_o), 128'd0);
        @(negedge clk);
        chk("async_slot_o", 128'(slot_o), 128'd0);
        @(posedge clk); #1;
        reset_n  = 1'b1;
        host_rdy = 1'b1;
        push_pkt(1); push_pkt(3);
        @(negedge clk);
        chk("post_rst_grant", 128'(yumi_o), 128'b0010);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 4) chk("post_rst_grant2", 128'(yumi_o), 128'b1000);
        end
        @(posedge clk); #1;
        v_i = '0;
        wait_drain("post_rst");

        // Three packets from a fresh reset, then the completed-packet count.
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        v_i = 4'b0111;
        push_pkt(0); push_pkt(1); push_pkt(2);
        @(negedge clk);
        chk("cnt_grant0", 128'(yumi_o), 128'b0001);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 4) chk("cnt_grant1", 128'(yumi_o), 128'b0010);
            if (n == 8) chk("cnt_grant2", 128'(yumi_o), 128'b0100);
        end
        @(posedge clk); #1;
        v_i = '0;
        wait_drain("cnt");
        chk("pkt_count", 128'(pkt_count_o), 128'(EXP_CNT3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
